// File: rtl/mcpu_mem_pfetch_client_if.sv
// Arbiter client port plus the line stream towards the consumer.
// master = prefetch client, slave = arbiter/consumer side.
interface mcpu_mem_pfetch_client_if;
  logic         cli2arb_valid;
  logic [2:0]   cli2arb_opcode;
  logic [26:0]  cli2arb_addr;
  logic [255:0] cli2arb_wdata;
  logic [31:0]  cli2arb_wbe;
  logic         cli2arb_stall;
  logic [255:0] cli2arb_rdata;
  logic         cli2arb_rvalid;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;

  modport master (
    output cli2arb_valid, cli2arb_opcode, cli2arb_addr, cli2arb_wdata, cli2arb_wbe,
    output out_valid, out_data,
    input  cli2arb_stall, cli2arb_rdata, cli2arb_rvalid, out_ready
  );

  modport slave (
    input  cli2arb_valid, cli2arb_opcode, cli2arb_addr, cli2arb_wdata, cli2arb_wbe,
    input  out_valid, out_data,
    output cli2arb_stall, cli2arb_rdata, cli2arb_rvalid, out_ready
  );
endinterface

// File: rtl/mcpu_mem_pfetch_client.sv
// Streaming line-read client: reads line_count 32-byte lines into a credit-managed FIFO.
// Define MCPU_MEM_PFETCH_STATS_EN to add the stall_cycles counter output.
module mcpu_mem_pfetch_client #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_BITS  = 3,
  parameter int unsigned LEN_BITS   = 16
) (
  input  logic                    clkrst_mem_clk,
  input  logic                    clkrst_mem_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [26:0]             base_addr,
  input  logic [LEN_BITS-1:0]     line_count,
  output logic                    busy,
  output logic                    done,
`ifdef MCPU_MEM_PFETCH_STATS_EN
  output logic [31:0]             stall_cycles,
`endif
  mcpu_mem_pfetch_client_if.master bus
);

  localparam logic [2:0]           LTC_OPC_READ = 3'd0;
  localparam logic [FIFO_BITS+1:0] DEPTH_W      = (FIFO_BITS + 2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

  state_e               state_q;
  logic [26:0]          addr_q;
  logic [LEN_BITS-1:0]  count_q, issued_q, issued_nxt;
  logic [FIFO_BITS:0]   outst_q, outst_nxt, fifo_cnt_q, cnt_nxt;
  logic [FIFO_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic                 valid_q, aborted_q, busy_q, done_q;
  logic [255:0]         mem_q [FIFO_DEPTH];

  logic acc, active, flush, drop, push, pop, out_valid_w, credit_ok, stalled;

  always_comb begin
    out_valid_w = (fifo_cnt_q != '0);
    stalled     = valid_q && bus.cli2arb_stall;
    acc         = valid_q && !bus.cli2arb_stall;
    active      = (state_q == StIssue) || (state_q == StDrain);
    flush       = active && abort;
    // Once aborted every return is dropped and the FIFO stays empty.
    drop        = aborted_q || flush;
    push        = bus.cli2arb_rvalid && !drop;
    pop         = out_valid_w && bus.out_ready && !drop;
    issued_nxt  = issued_q + {{(LEN_BITS-1){1'b0}}, acc};
    outst_nxt   = outst_q + {{FIFO_BITS{1'b0}}, acc} - {{FIFO_BITS{1'b0}}, bus.cli2arb_rvalid};
    cnt_nxt     = flush ? '0 :
                  fifo_cnt_q + {{FIFO_BITS{1'b0}}, push} - {{FIFO_BITS{1'b0}}, pop};
    // Credit is checked on next-cycle occupancy so a freshly raised valid is always covered.
    credit_ok   = ({1'b0, outst_nxt} + {1'b0, cnt_nxt}) < DEPTH_W;
  end

  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      aborted_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      issued_q   <= issued_nxt;
      outst_q    <= outst_nxt;
      fifo_cnt_q <= cnt_nxt;
      done_q     <= 1'b0;
      if (acc) addr_q <= addr_q + 27'd1;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q    <= base_addr;
            count_q   <= line_count;
            issued_q  <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            if (line_count != '0) begin
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (flush) begin
            aborted_q <= 1'b1;
            state_q   <= StDrain;
            valid_q   <= stalled;
          end else if (issued_nxt == count_q) begin
            state_q <= StDrain;
            valid_q <= 1'b0;
          end else begin
            valid_q <= stalled || credit_ok;
          end
        end
        StDrain: begin
          if (flush) aborted_q <= 1'b1;
          // A request stalled at abort time is held until the arbiter takes it.
          valid_q <= stalled;
          if (!valid_q && outst_q == '0 && fifo_cnt_q == '0) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clkrst_mem_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.cli2arb_rdata;
  end

`ifdef MCPU_MEM_PFETCH_STATS_EN
  logic [31:0] stall_cycles_q;
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      stall_cycles_q <= '0;
    end else if (state_q == StIdle && start) begin
      stall_cycles_q <= '0;
    end else if (stalled && stall_cycles_q != 32'hFFFF_FFFF) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end
  assign stall_cycles = stall_cycles_q;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign bus.cli2arb_valid  = valid_q;
  assign bus.cli2arb_opcode = LTC_OPC_READ;
  assign bus.cli2arb_addr   = addr_q;
  assign bus.cli2arb_wdata  = '0;
  assign bus.cli2arb_wbe    = '0;
  assign bus.out_valid      = out_valid_w;
  assign bus.out_data       = mem_q[rd_ptr_q];

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clkrst_mem_clk) disable iff (clkrst_mem_rst)
    bus.cli2arb_rvalid |-> (outst_q != '0));
`endif

endmodule
